// File: rtl/vdp_super_vram_arbiter.sv
// VRAM slot arbiter: display > refresh > CPU/cmd round-robin, one access per 4-clock dot slot.
// Latency: request sampled at AP, strobe after FS, ack and read data after DR (3 clocks from AP).
// Backpressure: CPU/cmd hold req until their 1-clock ack; display and refresh can starve them.
module vdp_super_vram_arbiter #(
    parameter int ADDR_W        = 17,
    parameter int REFRESH_SLOTS = 96
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [1:0]        dot_state,
    input  logic              disp_req,
    input  logic [ADDR_W-1:0] disp_addr,
    input  logic              cpu_req,
    input  logic              cpu_wr,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [31:0]       cpu_wdata,
    input  logic [3:0]        cpu_wmask,
    output logic              cpu_ack,
    input  logic              cmd_req,
    input  logic              cmd_wr,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [31:0]       cmd_wdata,
    input  logic [3:0]        cmd_wmask,
    output logic              cmd_ack,
    output logic [31:0]       req_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd,
    output logic              mem_wr,
    output logic              mem_refresh,
    output logic [31:0]       mem_wdata,
    output logic [3:0]        mem_wmask,
    input  logic [31:0]       mem_rdata,
    output logic              refresh_overrun
);

    localparam logic [1:0] PH_AP = 2'd2;
    localparam logic [1:0] PH_FS = 2'd3;
    localparam logic [1:0] PH_DL = 2'd0;
    localparam logic [1:0] PH_DR = 2'd1;
    localparam int         CNT_W = 10;
    localparam logic [CNT_W-1:0] REF_LAST = CNT_W'(REFRESH_SLOTS - 1);

    typedef enum logic [2:0] {OWN_IDLE, OWN_DISP, OWN_REF, OWN_CPU, OWN_CMD} owner_t;

    typedef struct packed {
        logic              wr;
        logic [ADDR_W-1:0] addr;
        logic [31:0]       wdata;
        logic [3:0]        wmask;
    } mem_req_t;

    owner_t           owner_q, owner_d, grant;
    mem_req_t         sel_req;
    logic             slot_wr_q;
    logic             prev_ap_q;
    logic             issued_q;
    logic             rr_cmd_q;
    logic [CNT_W-1:0] ref_cnt_q;
    logic             ref_pend_q, ref_pend_d;
    logic             ref_wrap, ref_grant, ovr_set;
    logic             elig_cpu, elig_cmd;
    logic             grant_rw, owner_rw;

    always_comb begin
        // an ack still showing means the held req belongs to the access just finished
        elig_cpu = cpu_req && !cpu_ack;
        elig_cmd = cmd_req && !cmd_ack;
        grant    = OWN_IDLE;
        if (disp_req)                grant = OWN_DISP;
        else if (ref_pend_q)         grant = OWN_REF;
        else if (elig_cpu && elig_cmd) grant = rr_cmd_q ? OWN_CMD : OWN_CPU;
        else if (elig_cpu)           grant = OWN_CPU;
        else if (elig_cmd)           grant = OWN_CMD;

        sel_req  = (grant == OWN_CMD) ? {cmd_wr, cmd_addr, cmd_wdata, cmd_wmask}
                                      : {cpu_wr, cpu_addr, cpu_wdata, cpu_wmask};
        grant_rw = (grant == OWN_CPU) || (grant == OWN_CMD);
        owner_rw = (owner_q == OWN_CPU) || (owner_q == OWN_CMD);

        owner_d = owner_q;
        case (dot_state)
            PH_AP:   owner_d = grant;
            PH_FS:   if (!prev_ap_q) owner_d = OWN_IDLE;
            PH_DL:   if (!issued_q) owner_d = OWN_IDLE;
            default: owner_d = OWN_IDLE;
        endcase

        ref_wrap   = (dot_state == PH_FS) && (ref_cnt_q == REF_LAST);
        ref_grant  = (dot_state == PH_AP) && (grant == OWN_REF);
        ref_pend_d = (ref_pend_q && !ref_grant) || ref_wrap;
        ovr_set    = ref_wrap && ref_pend_q && !ref_grant;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            owner_q         <= OWN_IDLE;
            slot_wr_q       <= 1'b0;
            prev_ap_q       <= 1'b0;
            issued_q        <= 1'b0;
            rr_cmd_q        <= 1'b0;
            ref_cnt_q       <= '0;
            ref_pend_q      <= 1'b0;
            refresh_overrun <= 1'b0;
            mem_addr        <= '0;
            mem_wdata       <= '0;
            mem_wmask       <= '0;
            mem_rd          <= 1'b0;
            mem_wr          <= 1'b0;
            mem_refresh     <= 1'b0;
            cpu_ack         <= 1'b0;
            cmd_ack         <= 1'b0;
            req_rdata       <= '0;
        end else begin
            owner_q     <= owner_d;
            prev_ap_q   <= (dot_state == PH_AP);
            ref_pend_q  <= ref_pend_d;
            mem_rd      <= 1'b0;
            mem_wr      <= 1'b0;
            mem_refresh <= 1'b0;
            cpu_ack     <= 1'b0;
            cmd_ack     <= 1'b0;
            if (ovr_set) refresh_overrun <= 1'b1;
            case (dot_state)
                PH_AP: begin
                    issued_q <= 1'b0;
                    if (grant == OWN_DISP) begin
                        mem_addr  <= disp_addr;
                        slot_wr_q <= 1'b0;
                    end else if (grant_rw) begin
                        mem_addr  <= sel_req.addr;
                        mem_wdata <= sel_req.wdata;
                        mem_wmask <= sel_req.wmask;
                        slot_wr_q <= sel_req.wr;
                    end
                end
                PH_FS: begin
                    ref_cnt_q <= ref_wrap ? '0 : ref_cnt_q + CNT_W'(1);
                    // only a slot that came straight from its AP may touch memory
                    if (prev_ap_q && owner_q != OWN_IDLE) begin
                        issued_q    <= 1'b1;
                        mem_refresh <= (owner_q == OWN_REF);
                        mem_wr      <= owner_rw && slot_wr_q;
                        mem_rd      <= (owner_q == OWN_DISP) || (owner_rw && !slot_wr_q);
                    end
                end
                PH_DR: begin
                    issued_q <= 1'b0;
                    if (issued_q && owner_rw) begin
                        cpu_ack  <= (owner_q == OWN_CPU);
                        cmd_ack  <= (owner_q == OWN_CMD);
                        rr_cmd_q <= (owner_q == OWN_CPU);
                        if (!slot_wr_q) req_rdata <= mem_rdata;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_vdp_super_vram_arbiter.sv
// Bench for vdp_super_vram_arbiter: directed slot table, hand sequences, randomized slots vs model.
module tb_vdp_super_vram_arbiter;
    localparam int AW = 17;
    localparam int RS = 4;
    localparam int O_IDLE = 0, O_DISP = 1, O_REF = 2, O_CPU = 3, O_CMD = 4;

    logic          clk = 1'b0;
    logic          reset_n;
    logic [1:0]    dot_state;
    logic          disp_req;
    logic [AW-1:0] disp_addr;
    logic          cpu_req, cpu_wr, cmd_req, cmd_wr;
    logic [AW-1:0] cpu_addr, cmd_addr;
    logic [31:0]   cpu_wdata, cmd_wdata;
    logic [3:0]    cpu_wmask, cmd_wmask;
    logic          cpu_ack, cmd_ack;
    logic [31:0]   req_rdata;
    logic [AW-1:0] mem_addr;
    logic          mem_rd, mem_wr, mem_refresh;
    logic [31:0]   mem_wdata;
    logic [3:0]    mem_wmask;
    logic [31:0]   mem_rdata;
    logic          refresh_overrun;

    always #5 clk = ~clk;

    vdp_super_vram_arbiter #(.ADDR_W(AW), .REFRESH_SLOTS(RS)) dut (
        .clk(clk), .reset_n(reset_n), .dot_state(dot_state),
        .disp_req(disp_req), .disp_addr(disp_addr),
        .cpu_req(cpu_req), .cpu_wr(cpu_wr), .cpu_addr(cpu_addr),
        .cpu_wdata(cpu_wdata), .cpu_wmask(cpu_wmask), .cpu_ack(cpu_ack),
        .cmd_req(cmd_req), .cmd_wr(cmd_wr), .cmd_addr(cmd_addr),
        .cmd_wdata(cmd_wdata), .cmd_wmask(cmd_wmask), .cmd_ack(cmd_ack),
        .req_rdata(req_rdata), .mem_addr(mem_addr), .mem_rd(mem_rd),
        .mem_wr(mem_wr), .mem_refresh(mem_refresh), .mem_wdata(mem_wdata),
        .mem_wmask(mem_wmask), .mem_rdata(mem_rdata),
        .refresh_overrun(refresh_overrun)
    );

    int n_checks = 0;
    int n_errors = 0;

    // expected state of the registered memory-side outputs
    logic [AW-1:0] e_addr;
    logic [31:0]   e_wdata, e_rdata;
    logic [3:0]    e_wmask;

    // reference model state
    bit m_pend, m_ovr, m_rr_cmd;
    int m_fs, m_last;

    typedef struct {
        bit d;
        bit c;
        bit m;
        bit drop;
        int own;
    } vec_t;
    vec_t tbl[15];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic clear_expect();
        e_addr  = '0;
        e_wdata = '0;
        e_wmask = '0;
        e_rdata = '0;
        m_pend  = 0;
        m_ovr   = 0;
        m_rr_cmd = 0;
        m_fs    = 0;
        m_last  = O_IDLE;
    endtask

    // One full AP,FS,DL,DR slot; own is the owner the bench expects to win it.
    task automatic do_slot(input bit d, input bit c, input bit m, input bit c_drop, input bit m_drop,
                           input logic [31:0] rdat, input int own, input bit exp_ovr);
        bit rd_exp, wr_exp;
        rd_exp = 0;
        wr_exp = 0;
        disp_req  = d;
        cpu_req   = c;
        cmd_req   = m;
        dot_state = 2'd2;
        mem_rdata = ~rdat;
        case (own)
            O_DISP: begin e_addr = disp_addr; rd_exp = 1; end
            O_CPU:  begin e_addr = cpu_addr; e_wdata = cpu_wdata; e_wmask = cpu_wmask;
                          rd_exp = !cpu_wr; wr_exp = cpu_wr; end
            O_CMD:  begin e_addr = cmd_addr; e_wdata = cmd_wdata; e_wmask = cmd_wmask;
                          rd_exp = !cmd_wr; wr_exp = cmd_wr; end
            default: ;
        endcase
        tick();
        if (c_drop) cpu_req = 1'b0;
        if (m_drop) cmd_req = 1'b0;
        chk("ap_addr", 32'(mem_addr), 32'(e_addr));
        if (own == O_CPU || own == O_CMD) begin
            chk("ap_wdata", mem_wdata, e_wdata);
            chk("ap_wmask", 32'(mem_wmask), 32'(e_wmask));
        end
        chk("ap_quiet", 32'({mem_rd, mem_wr, mem_refresh, cpu_ack, cmd_ack}), 32'd0);
        dot_state = 2'd3;
        tick();
        chk("fs_rd", 32'(mem_rd), 32'(rd_exp));
        chk("fs_wr", 32'(mem_wr), 32'(wr_exp));
        chk("fs_refresh", 32'(mem_refresh), 32'(own == O_REF));
        dot_state = 2'd0;
        mem_rdata = rdat;
        tick();
        chk("dl_strobes", 32'({mem_rd, mem_wr, mem_refresh}), 32'd0);
        dot_state = 2'd1;
        tick();
        if ((own == O_CPU || own == O_CMD) && rd_exp) e_rdata = rdat;
        chk("dr_cpu_ack", 32'(cpu_ack), 32'(own == O_CPU));
        chk("dr_cmd_ack", 32'(cmd_ack), 32'(own == O_CMD));
        chk("dr_rdata", req_rdata, e_rdata);
        chk("dr_strobes", 32'({mem_rd, mem_wr, mem_refresh}), 32'd0);
        chk("dr_overrun", 32'(refresh_overrun), 32'(exp_ovr));
    endtask

    // Slot-level model: priority list, round-robin, refresh every RS-th FS since reset.
    task automatic model_slot(input bit d, input bit c, input bit m, output int own, output bit ovr);
        bit ec, em;
        ec = c && (m_last != O_CPU);
        em = m && (m_last != O_CMD);
        if (d) own = O_DISP;
        else if (m_pend) begin own = O_REF; m_pend = 0; end
        else if (ec && em) own = m_rr_cmd ? O_CMD : O_CPU;
        else if (ec) own = O_CPU;
        else if (em) own = O_CMD;
        else own = O_IDLE;
        m_fs++;
        if (m_fs % RS == 0) begin
            if (m_pend) m_ovr = 1;
            m_pend = 1;
        end
        if (own == O_CPU) m_rr_cmd = 1;
        if (own == O_CMD) m_rr_cmd = 0;
        m_last = own;
        ovr = m_ovr;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        clear_expect();
    endtask

    initial begin
        int own;
        bit ovr, d, c, m;

        tbl[0]  = '{0, 1, 1, 0, O_CPU};
        tbl[1]  = '{0, 1, 1, 0, O_CMD};
        tbl[2]  = '{0, 1, 1, 0, O_CPU};
        tbl[3]  = '{0, 1, 1, 0, O_CMD};
        tbl[4]  = '{0, 1, 1, 0, O_REF};
        tbl[5]  = '{0, 1, 1, 0, O_CPU};
        tbl[6]  = '{1, 1, 1, 0, O_DISP};
        tbl[7]  = '{1, 1, 1, 0, O_DISP};
        tbl[8]  = '{1, 1, 0, 0, O_DISP};
        tbl[9]  = '{0, 1, 0, 0, O_REF};
        tbl[10] = '{0, 1, 0, 0, O_CPU};
        tbl[11] = '{0, 0, 1, 0, O_CMD};
        tbl[12] = '{0, 0, 0, 0, O_REF};
        tbl[13] = '{0, 0, 0, 0, O_IDLE};
        tbl[14] = '{0, 0, 1, 1, O_CMD};

        reset_n = 1'b0; dot_state = 2'd1; disp_req = 0; disp_addr = 17'h1F00F;
        cpu_req = 0; cpu_wr = 0; cpu_addr = '0; cpu_wdata = '0; cpu_wmask = '0;
        cmd_req = 0; cmd_wr = 0; cmd_addr = '0; cmd_wdata = '0; cmd_wmask = '0;
        mem_rdata = '0;
        clear_expect();
        @(negedge clk);
        tick();
        chk("rst_addr", 32'(mem_addr), 32'd0);
        chk("rst_outs", 32'({mem_rd, mem_wr, mem_refresh, cpu_ack, cmd_ack, refresh_overrun}), 32'd0);
        chk("rst_rdata", req_rdata, 32'd0);
        reset_n = 1'b1;

        // start a CPU write, then reset in the middle of the slot
        cpu_req = 1; cpu_wr = 1; cpu_addr = 17'h00055; cpu_wdata = 32'h11112222; cpu_wmask = 4'hF;
        dot_state = 2'd2;
        tick();
        chk("pre_rst_addr", 32'(mem_addr), 32'h55);
        dot_state = 2'd3;
        reset_n = 1'b0;
        #1;
        chk("midrst_addr", 32'(mem_addr), 32'd0);
        chk("midrst_data", mem_wdata, 32'd0);
        @(negedge clk);
        chk("midrst_strobes", 32'({mem_rd, mem_wr, mem_refresh}), 32'd0);
        dot_state = 2'd0; tick();
        dot_state = 2'd1; tick();
        chk("midrst_ack", 32'({cpu_ack, cmd_ack, refresh_overrun}), 32'd0);
        reset_n = 1'b1;
        clear_expect();

        cpu_wr = 0; cpu_addr = 17'h00123; cpu_wdata = 32'h0BADF00D; cpu_wmask = 4'hC;
        cmd_wr = 1; cmd_addr = 17'h0ABCD; cmd_wdata = 32'hDEADBEEF; cmd_wmask = 4'b0101;
        for (int i = 0; i < 15; i++)
            do_slot(tbl[i].d, tbl[i].c, tbl[i].m, tbl[i].drop, tbl[i].drop,
                    32'hA5A5A5A5 ^ (32'(i) * 32'h01010101), tbl[i].own, 1'b0);

        // phase skip AP->DL: granted slot is dropped, CPU wins the next full slot
        cpu_req = 1; cpu_wr = 0; cpu_addr = 17'h00777; cmd_req = 0; disp_req = 0;
        dot_state = 2'd2;
        tick();
        e_addr = cpu_addr; e_wdata = cpu_wdata; e_wmask = cpu_wmask;
        chk("skip_addr", 32'(mem_addr), 32'(e_addr));
        dot_state = 2'd0; tick();
        chk("skip_dl", 32'({mem_rd, mem_wr, mem_refresh}), 32'd0);
        dot_state = 2'd1; mem_rdata = 32'h5A5A0000; tick();
        chk("skip_ack", 32'({cpu_ack, cmd_ack}), 32'd0);
        chk("skip_rdata", req_rdata, e_rdata);
        do_slot(0, 1, 0, 0, 0, 32'h0F0F1234, O_CPU, 1'b0);

        // display hogs 10 slots: two refresh wraps, second one overruns
        do_reset();
        cpu_wr = 0; cpu_addr = 17'h00200;
        for (int k = 1; k <= 10; k++)
            do_slot(1, 1, 0, 0, 0, 32'(k) * 32'h00370001, O_DISP, k >= 8);
        do_slot(0, 1, 0, 0, 0, 32'h13572468, O_REF, 1'b1);
        do_slot(0, 1, 0, 0, 0, 32'h24681357, O_CPU, 1'b1);

        do_reset();
        for (int s = 0; s < 400; s++) begin
            d = ($urandom % 4) == 0;
            c = ($urandom % 3) != 0;
            m = ($urandom % 3) != 0;
            disp_addr = AW'($urandom);
            cpu_wr = 1'($urandom); cpu_addr = AW'($urandom);
            cpu_wdata = $urandom; cpu_wmask = 4'($urandom);
            cmd_wr = 1'($urandom); cmd_addr = AW'($urandom);
            cmd_wdata = $urandom; cmd_wmask = 4'($urandom);
            model_slot(d, c, m, own, ovr);
            do_slot(d, c, m, 1'($urandom), 1'($urandom), $urandom, own, ovr);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
